dsadc1i: RTL

- First-order delta-sigma ADC front end and decimator. It is the receive-side counterpart of the first-order delta-sigma DAC in the audio path.
- It samples an external comparator (LVDS pair or pin plus RC network) and drives the 1-bit feedback that closes the analog loop.
- It decimates the resulting bitstream with an order-2 CIC into excess-2**MSBI PCM samples. The format matches the DAC input, so samples can feed the DAC, tape-in and mixer logic directly.

---
 rtl/dsadc_pkg.sv | 20 ++
 rtl/dsadc1i_if.sv | 14 +
 rtl/dsadc1i_cic2_comb.sv | 28 ++
 rtl/dsadc1i.sv | 81 ++++++++
 4 files changed

// File: rtl/dsadc_pkg.sv
// Shared sizing helpers for the first-order delta-sigma ADC front end:
// accumulator width, decimation ratio, output scaling shift and settle count.
package dsadc_pkg;

  // Two decim events must prime the comb delays before a sample is meaningful.
  localparam int SETTLE_COUNT = 2;

  function automatic int acc_width(input int decim_log2);
    return 2 * decim_log2 + 1;
  endfunction

  function automatic int decim_ratio(input int decim_log2);
    return 1 << decim_log2;
  endfunction

  function automatic int scale_shift(input int msbi, input int decim_log2);
    return 2 * decim_log2 - msbi - 1;
  endfunction

endpackage

// File: rtl/dsadc1i_if.sv
// Bundle of the analog-loop and PCM sample signals of dsadc1i.
// adc_valid is a one-clock strobe with no ready: the consumer must take
// adc_out on the strobe cycle; adc_out holds its value between strobes.
interface dsadc1i_if #(
  parameter int MSBI = 15
);
  logic            cmp_in;
  logic            fb;
  logic [MSBI:0]   adc_out;
  logic            adc_valid;

  modport master (output cmp_in, input fb, input adc_out, input adc_valid);
  modport slave  (input cmp_in, output fb, output adc_out, output adc_valid);
endinterface

// File: rtl/dsadc1i_cic2_comb.sv
// Two-stage comb section of the order-2 CIC decimator; stages and their
// delay registers advance only on decim events.
module cic2_comb #(
  parameter int W = 17
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_c2
);
  logic [W-1:0] r_xd;
  logic [W-1:0] r_c1d;
  logic [W-1:0] w_c1;

  assign w_c1 = i_x - r_xd;
  assign o_c2 = w_c1 - r_c1d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xd  <= '0;
      r_c1d <= '0;
    end else if (i_en) begin
      r_xd  <= i_x;
      r_c1d <= w_c1;
    end
  end
endmodule

// File: rtl/dsadc1i.sv
// First-order delta-sigma ADC: comparator synchroniser, 1-bit feedback,
// order-2 CIC decimation to excess-2**MSBI PCM samples.
module dsadc1i
  import dsadc_pkg::*;
#(
  parameter int MSBI       = 15,
  parameter int DECIM_LOG2 = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CMP_IN,
  output logic          FB,
  output logic [MSBI:0] ADCout,
  output logic          ADCvalid
);
  localparam int W  = acc_width(DECIM_LOG2);
  localparam int SH = scale_shift(MSBI, DECIM_LOG2);

  if (2 * DECIM_LOG2 < MSBI + 1) begin : g_bad_params
    $error("dsadc1i: 2*DECIM_LOG2 must be at least MSBI+1");
  end

  logic                  r_s1;
  logic                  r_s2;
  logic [W-1:0]          r_i1;
  logic [W-1:0]          r_i2;
  logic [DECIM_LOG2-1:0] r_cnt;
  logic [1:0]            r_settle;
  logic [MSBI:0]         r_out;
  logic                  r_valid;
  logic                  w_decim;
  logic [W-1:0]          w_c2;
  logic [MSBI:0]         w_scaled;

  assign w_decim  = (r_cnt == '1);
  assign FB       = r_s2;
  assign ADCout   = r_out;
  assign ADCvalid = r_valid;

  cic2_comb #(.W(W)) u_comb (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_en  (w_decim),
    .i_x   (r_i2),
    .o_c2  (w_c2)
  );

  // c2 only reaches bit W-1 at full scale (R*R), which would wrap to 0.
  always_comb begin
    w_scaled = w_c2[SH +: MSBI+1];
    if (w_c2[W-1]) w_scaled = '1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_i1     <= '0;
      r_i2     <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_s1    <= CMP_IN;
      r_s2    <= r_s1;
      r_i1    <= r_i1 + W'(r_s2);
      r_i2    <= r_i2 + r_i1;
      r_cnt   <= r_cnt + DECIM_LOG2'(1);
      r_valid <= 1'b0;
      if (w_decim) begin
        if (r_settle != 2'(SETTLE_COUNT)) begin
          r_settle <= r_settle + 2'd1;
        end else begin
          r_valid <= 1'b1;
          r_out   <= w_scaled;
        end
      end
    end
  end
endmodule
